// File: rtl/dual_port_ram_pkg.sv
// dual_port_ram_pkg: shared size defaults for the dual-port RAM.
//   DATA_W_DEF : default word width
//   ADDR_W_DEF : default address width
//   DEPTH      : default number of words (2**ADDR_W_DEF)
package dual_port_ram_pkg;
    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 3;
    localparam int DEPTH      = 2 ** ADDR_W_DEF;
endpackage

// File: rtl/dual_port_ram_port.sv
// dual_port_ram_port: registered read-data path of one RAM port.
//   clk, rst_n : clock, synchronous active-low reset
//   en_i, wr_i : port enable and write strobe
//   rdata_i    : current array word at this port's address
//   dout_o     : registered read data; holds on writes and idle cycles
module dual_port_ram_port
    import dual_port_ram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en_i,
    input  logic              wr_i,
    input  logic [DATA_W-1:0] rdata_i,
    output logic [DATA_W-1:0] dout_o
);
    logic [DATA_W-1:0] dout_q, dout_d;

    always_comb dout_d = (en_i && !wr_i) ? rdata_i : dout_q;

    always_ff @(posedge clk) begin
        if (!rst_n) dout_q <= '0;
        else        dout_q <= dout_d;
    end

    assign dout_o = dout_q;
endmodule

// File: rtl/dual_port_ram.sv
// dual_port_ram: true dual-port synchronous RAM with write-write collision flag.
//   clk, rst_n              : clock, synchronous active-low reset
//   enA/wrA/addA/dinA/doutA : port A enable, write strobe, address, data in/out
//   enB/wrB/addB/dinB/doutB : port B enable, write strobe, address, data in/out
//   collision               : registered; high one cycle after a same-address dual write
module dual_port_ram
    import dual_port_ram_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enA,
    input  logic              wrA,
    input  logic [ADDR_W-1:0] addA,
    input  logic [DATA_W-1:0] dinA,
    output logic [DATA_W-1:0] doutA,
    input  logic              enB,
    input  logic              wrB,
    input  logic [ADDR_W-1:0] addB,
    input  logic [DATA_W-1:0] dinB,
    output logic [DATA_W-1:0] doutB,
    output logic              collision
);
    localparam int DEPTH_L = 2 ** ADDR_W;

    logic [DATA_W-1:0] mem_q [DEPTH_L];
    logic [DATA_W-1:0] mem_d [DEPTH_L];
    logic              collision_q, collision_d;
    logic              wr_a, wr_b;

    assign wr_a = enA && wrA;
    assign wr_b = enB && wrB;

    // Port A is applied last so it overrides B on a same-address write.
    always_comb begin
        mem_d = mem_q;
        if (wr_b) mem_d[addB] = dinB;
        if (wr_a) mem_d[addA] = dinA;
        collision_d = wr_a && wr_b && (addA == addB);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_q       <= '{default: '0};
            collision_q <= 1'b0;
        end else begin
            mem_q       <= mem_d;
            collision_q <= collision_d;
        end
    end

    // Read ports sample the pre-edge array, giving read-first behaviour.
    dual_port_ram_port #(.DATA_W(DATA_W)) u_port_a (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (enA),
        .wr_i   (wrA),
        .rdata_i(mem_q[addA]),
        .dout_o (doutA)
    );

    dual_port_ram_port #(.DATA_W(DATA_W)) u_port_b (
        .clk    (clk),
        .rst_n  (rst_n),
        .en_i   (enB),
        .wr_i   (wrB),
        .rdata_i(mem_q[addB]),
        .dout_o (doutB)
    );

    assign collision = collision_q;
endmodule

// File: tb/tb_dual_port_ram.sv
// tb_dual_port_ram: self-checking bench for dual_port_ram against a behavioural model.
module tb_dual_port_ram;
    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       enA = 1'b0, wrA = 1'b0, enB = 1'b0, wrB = 1'b0;
    logic [2:0] addA = '0, addB = '0;
    logic [7:0] dinA = '0, dinB = '0;
    logic [7:0] doutA, doutB;
    logic       collision;

    logic [7:0] mdl [8];
    logic [7:0] xa, xb;
    logic       xc;
    int         n_cmp = 0;
    int         n_fail = 0;

    dual_port_ram dut (
        .clk(clk), .rst_n(rst_n),
        .enA(enA), .wrA(wrA), .addA(addA), .dinA(dinA), .doutA(doutA),
        .enB(enB), .wrB(wrB), .addB(addB), .dinB(dinB), .doutB(doutB),
        .collision(collision)
    );

    always #5 clk = ~clk;

    // Drive one cycle, predict the outcome from the RAM rules, then step past the edge.
    task automatic cyc(input logic r, input logic ea, input logic wa, input logic [2:0] aa,
                       input logic [7:0] da, input logic eb, input logic wb,
                       input logic [2:0] ab, input logic [7:0] db);
        rst_n = r; enA = ea; wrA = wa; addA = aa; dinA = da;
        enB = eb; wrB = wb; addB = ab; dinB = db;
        if (!r) begin
            for (int i = 0; i < 8; i++) mdl[i] = 8'h00;
            xa = 8'h00; xb = 8'h00; xc = 1'b0;
        end else begin
            if (ea && !wa) xa = mdl[aa];
            if (eb && !wb) xb = mdl[ab];
            xc = ea && wa && eb && wb && (aa == ab);
            if (xc) mdl[aa] = da;
            else begin
                if (ea && wa) mdl[aa] = da;
                if (eb && wb) mdl[ab] = db;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        cyc(1'b0, 1'b1, 1'b1, 3'd2, 8'hC3, 1'b1, 1'b1, 3'd5, 8'h3C);
        n_cmp++; if (doutA !== 8'h00) begin n_fail++; $display("FAIL reset_doutA got %h want 00", doutA); end
        n_cmp++; if (doutB !== 8'h00) begin n_fail++; $display("FAIL reset_doutB got %h want 00", doutB); end
        n_cmp++; if (collision !== 1'b0) begin n_fail++; $display("FAIL reset_collision got %b want 0", collision); end
        for (int a = 0; a < 8; a++) begin
            cyc(1'b1, 1'b1, 1'b0, 3'(a), 8'h00, 1'b1, 1'b0, 3'(7 - a), 8'h00);
            n_cmp++; if (doutA !== 8'h00) begin n_fail++; $display("FAIL reset_read_A[%0d] got %h want 00", a, doutA); end
            n_cmp++; if (doutB !== 8'h00) begin n_fail++; $display("FAIL reset_read_B[%0d] got %h want 00", 7 - a, doutB); end
        end
    endtask

    task automatic test_collision;
        logic [7:0] ta [4] = '{8'h4B, 8'h4B, 8'h7B, 8'h00};
        logic [7:0] tb [4] = '{8'h4F, 8'h0F, 8'h0E, 8'hFF};
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b1, 1'b1, 3'(i + 1), ta[i], 1'b1, 1'b1, 3'(i + 1), tb[i]);
            n_cmp++; if (collision !== 1'b1) begin n_fail++; $display("FAIL collision_flag[%0d] got %b want 1", i + 1, collision); end
        end
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 1'b1, 1'b0, 3'(i + 1), 8'h00, 1'b1, 1'b0, 3'(i + 1), 8'h00);
            n_cmp++; if (doutA !== ta[i]) begin n_fail++; $display("FAIL collision_read_A[%0d] got %h want %h", i + 1, doutA, ta[i]); end
            n_cmp++; if (doutB !== ta[i]) begin n_fail++; $display("FAIL collision_read_B[%0d] got %h want %h", i + 1, doutB, ta[i]); end
            n_cmp++; if (collision !== 1'b0) begin n_fail++; $display("FAIL collision_clear[%0d] got %b want 0", i + 1, collision); end
        end
    endtask

    task automatic test_cross_rdw;
        cyc(1'b1, 1'b1, 1'b1, 3'd1, 8'hAA, 1'b1, 1'b0, 3'd1, 8'h00);
        n_cmp++; if (doutB !== 8'h4B) begin n_fail++; $display("FAIL rdw_B_old got %h want 4b", doutB); end
        cyc(1'b1, 1'b0, 1'b0, 3'd0, 8'h00, 1'b1, 1'b0, 3'd1, 8'h00);
        n_cmp++; if (doutB !== 8'hAA) begin n_fail++; $display("FAIL rdw_B_new got %h want aa", doutB); end
        cyc(1'b1, 1'b1, 1'b0, 3'd2, 8'h00, 1'b1, 1'b1, 3'd2, 8'h55);
        n_cmp++; if (doutA !== 8'h4B) begin n_fail++; $display("FAIL rdw_A_old got %h want 4b", doutA); end
        n_cmp++; if (collision !== 1'b0) begin n_fail++; $display("FAIL rdw_collision got %b want 0", collision); end
        cyc(1'b1, 1'b1, 1'b0, 3'd2, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
        n_cmp++; if (doutA !== 8'h55) begin n_fail++; $display("FAIL rdw_A_new got %h want 55", doutA); end
    endtask

    task automatic test_enable;
        cyc(1'b1, 1'b0, 1'b1, 3'd3, 8'h12, 1'b0, 1'b0, 3'd4, 8'h00);
        n_cmp++; if (doutA !== 8'h55) begin n_fail++; $display("FAIL enable_hold_A got %h want 55", doutA); end
        n_cmp++; if (doutB !== 8'hAA) begin n_fail++; $display("FAIL enable_hold_B got %h want aa", doutB); end
        cyc(1'b1, 1'b1, 1'b0, 3'd3, 8'h00, 1'b0, 1'b1, 3'd3, 8'h34);
        n_cmp++; if (doutA !== 8'h7B) begin n_fail++; $display("FAIL enable_mem3 got %h want 7b", doutA); end
        n_cmp++; if (doutB !== 8'hAA) begin n_fail++; $display("FAIL enable_hold_B2 got %h want aa", doutB); end
    endtask

    task automatic test_own_write;
        cyc(1'b1, 1'b1, 1'b0, 3'd4, 8'h00, 1'b0, 1'b0, 3'd0, 8'h00);
        n_cmp++; if (doutA !== 8'h00) begin n_fail++; $display("FAIL own_read4 got %h want 00", doutA); end
        cyc(1'b1, 1'b1, 1'b1, 3'd5, 8'h99, 1'b1, 1'b1, 3'd6, 8'h33);
        n_cmp++; if (doutA !== 8'h00) begin n_fail++; $display("FAIL own_write_hold got %h want 00", doutA); end
        n_cmp++; if (collision !== 1'b0) begin n_fail++; $display("FAIL own_collision got %b want 0", collision); end
        cyc(1'b1, 1'b1, 1'b0, 3'd5, 8'h00, 1'b1, 1'b0, 3'd6, 8'h00);
        n_cmp++; if (doutA !== 8'h99) begin n_fail++; $display("FAIL own_mem5 got %h want 99", doutA); end
        n_cmp++; if (doutB !== 8'h33) begin n_fail++; $display("FAIL own_mem6 got %h want 33", doutB); end
    endtask

    task automatic test_random;
        logic       ea, wa, eb, wb, r;
        logic [2:0] aa, ab;
        logic [7:0] da, db;
        for (int n = 0; n < 400; n++) begin
            r  = ($urandom_range(0, 39) != 0);
            ea = $urandom_range(0, 3) != 0; wa = $urandom_range(0, 1) == 1;
            eb = $urandom_range(0, 3) != 0; wb = $urandom_range(0, 1) == 1;
            aa = 3'($urandom_range(0, 3)); ab = 3'($urandom_range(0, 3));
            da = wa ? 8'($urandom) : 8'bx;
            db = wb ? 8'($urandom) : 8'bx;
            cyc(r, ea, wa, aa, da, eb, wb, ab, db);
            n_cmp++; if (doutA !== xa) begin n_fail++; $display("FAIL rand_doutA[%0d] got %h want %h", n, doutA, xa); end
            n_cmp++; if (doutB !== xb) begin n_fail++; $display("FAIL rand_doutB[%0d] got %h want %h", n, doutB, xb); end
            n_cmp++; if (collision !== xc) begin n_fail++; $display("FAIL rand_collision[%0d] got %b want %b", n, collision, xc); end
        end
    endtask

    initial begin
        test_reset;
        test_collision;
        test_cross_rdw;
        test_enable;
        test_own_write;
        test_random;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
